instr_sequencer: RTL
====================

# instr_sequencer

Instruction fetch/issue controller for the 18-bit `instructdecoder`. It walks a program counter through a synchronous-read instruction memory and presents each fetched word on `id` with a valid/ready handshake. It stops on the halt opcode. It sits between program memory and the decoder, replacing hand-driven `id` stimulus with autonomous sequencing.

## Interface
Parameters:
- `AW`, 8: program-memory address width (program length up to 2^AW words).
- `START_ADDR`, 0: PC value loaded on reset and on every accepted `start`.
- `HALT_OP`, 4'b1000: value of `id[17:14]` that marks a halt instruction.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level-sampled request to begin execution from `START_ADDR`.
- `step`  in  1  single-step advance pulse; used only with `SEQ_STEP_EN`, ignored otherwise.
- `imem_rd`  out  1  program-memory read strobe.
- `imem_addr`  out  AW  program-memory read address; always equals `pc`.
- `imem_data`  in  18  read data, valid the cycle after `imem_rd`.
- `id`  out  18  instruction word to the decoder.
- `id_valid`  out  1  `id` holds an instruction awaiting acceptance.
- `id_ready`  in  1  decoder accepts `id` this cycle.
- `pc`  out  AW  current program counter.
- `busy`  out  1  high in every state except IDLE and HALTED.
- `halted`  out  1  high in HALTED.

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, HALTED, PAUSE (PAUSE is reachable only with `SEQ_STEP_EN`).
- IDLE:
  - `start`=1 loads `pc`←`START_ADDR` and moves to FETCH.
- FETCH:
  - `imem_rd`=1 for exactly one cycle at `imem_addr`=`pc`.
  - Moves to WAIT.
- WAIT:
  - `imem_data` is valid.
  - `id` is registered from `imem_data` on the exiting edge; moves to ISSUE.
- ISSUE:
  - `id_valid`=1, and `id` is held stable until the handshake.
  - Handshake is `id_valid & id_ready` sampled on a rising edge.
  - On handshake with `id[17:14]`==`HALT_OP`: go to HALTED; `pc` is not incremented.
  - On handshake with any other opcode: `pc`←`pc`+1, then go to FETCH (or PAUSE in step mode).
- HALTED:
  - `halted`=1; `id` retains the halt word.
  - `start`=1 reloads `pc`←`START_ADDR` and moves to FETCH.
- `start` in any state other than IDLE or HALTED is ignored.
- PC arithmetic is modulo 2^AW: `pc`=2^AW−1 increments to 0. This wrap is silent, with no flag.
- The decoder's clock is `clk`; `id` changes only on the WAIT→ISSUE edge.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state=IDLE, `pc`=`START_ADDR`, `id`=18'b0.
  - `id_valid`=0, `imem_rd`=0, `busy`=0, `halted`=0.
- Reset mid-operation:
  - All of the above apply at once.
  - An in-flight memory read is discarded.
  - No `id_valid` pulse may follow the deassertion of reset.
- Latency:
  - `start` sampled at edge N → `imem_rd` high in cycle N+1 (FETCH).
  - `id_valid` rises at edge N+3.
- Throughput: with `id_ready` tied high, one instruction every 3 cycles (FETCH, WAIT, ISSUE).
- Backpressure: `id_ready`=0 holds ISSUE indefinitely, with `id`, `pc` and `id_valid` stable.
- `id_valid` drops on the edge after the handshake. There is no back-to-back issue.

## Configuration
- Macro `INSTR_SEQ_STEP_EN`.
- Defined:
  - After every non-halt handshake the FSM enters PAUSE (`busy`=1, `id_valid`=0) instead of FETCH.
  - A `step`=1 sample in PAUSE moves to FETCH.
  - `step` in any other state is ignored.
  - The halt handshake still goes directly to HALTED.
- Undefined:
  - The PAUSE state and its logic are not compiled.
  - `step` is unconnected internally, and the FSM runs freely.

## Test plan
- Reset then `start` pulse, memory [0]=18'b110010100011001001, [1]=18'b000111010111101100, [2]=18'b100010111011001100, `id_ready`=1 → `id` presents the three words in order at 3-cycle spacing. `halted`=1 after the third handshake, with `pc`=2.
- Same program, `id_ready` held 0 for 5 cycles in the first ISSUE → `id`=18'b110010100011001001 and `pc`=0 stable throughout. Sequencing resumes one cycle after `id_ready`=1.
- `AW`=2, memory 0–3 with no halt, then halt at 0 on the second pass → `pc` sequence 0,1,2,3,0. Halts at `pc`=0.
- `rst_n` pulsed low during WAIT → all outputs reach reset values asynchronously. No `id_valid` occurs until the next `start`.
- In HALTED, pulse `start` → `pc`=`START_ADDR`, `halted`=0, and the program re-executes. A `start` asserted while in ISSUE has no effect.
- With `INSTR_SEQ_STEP_EN`, program of two rotate instructions plus halt → after each handshake `busy`=1 and `id_valid`=0 until `step`. Each `step` yields exactly one `id_valid` assertion.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue controller: walks pc through a synchronous-read program memory
// and hands each word to the decoder over id/id_valid/id_ready. Optional macro: INSTR_SEQ_STEP_EN.
module instr_sequencer #(
    parameter int              AW         = 8,
    parameter logic [AW-1:0]   START_ADDR = '0,
    parameter logic [3:0]      HALT_OP    = 4'b1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          step,
    output logic          imem_rd,
    output logic [AW-1:0] imem_addr,
    input  logic [17:0]   imem_data,
    output logic [17:0]   id,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALTED
`ifdef INSTR_SEQ_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] pc_reg;
    logic [17:0]   id_reg;
    logic          id_valid_reg;
    logic          imem_rd_reg;
    logic          busy_reg;
    logic          halted_reg;
    logic          start_pend_reg;

`ifndef INSTR_SEQ_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign id        = id_reg;
    assign id_valid  = id_valid_reg;
    assign imem_rd   = imem_rd_reg;
    assign busy      = busy_reg;
    assign halted    = halted_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            pc_reg         <= START_ADDR;
            id_reg         <= '0;
            id_valid_reg   <= 1'b0;
            imem_rd_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            halted_reg     <= 1'b0;
            start_pend_reg <= 1'b0;
        end else begin
            // start is captured only while stopped, then acted on one edge later;
            // this gives the sampled-start to id_valid latency of three edges.
            start_pend_reg <= start && (state_reg == S_IDLE || state_reg == S_HALTED);
            case (state_reg)
                S_IDLE, S_HALTED: begin
                    if (start_pend_reg) begin
                        state_reg   <= S_FETCH;
                        pc_reg      <= START_ADDR;
                        imem_rd_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        halted_reg  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state_reg   <= S_WAIT;
                    imem_rd_reg <= 1'b0;
                end
                S_WAIT: begin
                    state_reg    <= S_ISSUE;
                    id_reg       <= imem_data;
                    id_valid_reg <= 1'b1;
                end
                S_ISSUE: begin
                    if (id_ready) begin
                        id_valid_reg <= 1'b0;
                        if (id_reg[17:14] == HALT_OP) begin
                            state_reg  <= S_HALTED;
                            busy_reg   <= 1'b0;
                            halted_reg <= 1'b1;
                        end else begin
                            pc_reg <= pc_reg + AW'(1);
`ifdef INSTR_SEQ_STEP_EN
                            state_reg <= S_PAUSE;
`else
                            state_reg   <= S_FETCH;
                            imem_rd_reg <= 1'b1;
`endif
                        end
                    end
                end
`ifdef INSTR_SEQ_STEP_EN
                S_PAUSE: begin
                    if (step) begin
                        state_reg   <= S_FETCH;
                        imem_rd_reg <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_reg    <= S_IDLE;
                    id_valid_reg <= 1'b0;
                    imem_rd_reg  <= 1'b0;
                    busy_reg     <= 1'b0;
                    halted_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule
